mul_arb_256b_2ch: RTL and testbench

- Shares one 256b x 256b multi-cycle multiplier between two requesters, e.g. the point-add and point-double sequencers of the SM2 core.
- The multiplier is started by a rising edge on its valid input. It pulses its finish output roughly 17 cycles later and then presents a 512b product.
- This block arbitrates round-robin, latches the operands, issues a single start pulse, waits for finish with a watchdog, and returns the product to the owner.
- A drain period after reset or timeout guarantees a fresh start never overlaps an in-flight multiply.

---
 rtl/mul_arb_256b_2ch.sv | 202 ++++++++++++++++++++
 tb/tb_mul_arb_256b_2ch.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arb_256b_2ch.sv
// mul_arb_256b_2ch
//   Shares one 256b x 256b multi-cycle multiplier between two requesters.
//   Arbitration is round-robin. The arbiter latches the owner's operands,
//   issues a single start pulse, and waits for finish under a watchdog.
//   It then returns the registered product to the owner.
//   After reset or a watchdog timeout, a DRAIN period keeps a new start
//   from overlapping a multiply that may still be in flight.
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   req_vld_i[1:0]     per-channel request level, held until ack_o
//   req{0,1}_{a,b}_i   per-channel 256b operands
//   ack_o[1:0]         1-cycle pulse: request accepted, operands latched
//   done_o[1:0]        1-cycle pulse to owner: res_o valid this cycle
//   res_o[511:0]       registered product (0 after timeout), held until next done
//   err_o              sticky watchdog flag, cleared only by rst
//   busy_o             high in every state except IDLE
//   mul_vld_o          start pulse to the multiplier (rising edge starts it)
//   mul_a_o, mul_b_o   registered operands to the multiplier
//   mul_fin_i          multiplier finish pulse
//   mul_r_i[511:0]     multiplier product, valid with mul_fin_i

// Per-channel output decode: one instance per channel.
module mul_arb_256b_2ch_lane (
    input  logic is_owner,
    input  logic in_issue,
    input  logic in_done,
    output logic ack,
    output logic done
);
    assign ack  = is_owner & in_issue;
    assign done = is_owner & in_done;
endmodule

module mul_arb_256b_2ch #(
    parameter int TIMEOUT = 32,
    parameter int DRAIN   = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_vld_i,
    input  logic [255:0] req0_a_i,
    input  logic [255:0] req0_b_i,
    input  logic [255:0] req1_a_i,
    input  logic [255:0] req1_b_i,
    output logic [1:0]   ack_o,
    output logic [1:0]   done_o,
    output logic [511:0] res_o,
    output logic         err_o,
    output logic         busy_o,
    output logic         mul_vld_o,
    output logic [255:0] mul_a_o,
    output logic [255:0] mul_b_o,
    input  logic         mul_fin_i,
    input  logic [511:0] mul_r_i
);
    localparam int NUM_LANES = 2;
    localparam int VEC_W     = 256;
    localparam int WD_W      = $clog2(TIMEOUT + 1);
    localparam int DR_W      = $clog2(DRAIN + 1);

    typedef enum logic [2:0] {
        S_DRAIN,
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [VEC_W-1:0] a;
        logic [VEC_W-1:0] b;
    } req_t;

    req_t [NUM_LANES-1:0] req;

    assign req[0] = '{a: req0_a_i, b: req0_b_i};
    assign req[1] = '{a: req1_a_i, b: req1_b_i};

    state_t            state, state_n;
    logic              owner;      // channel that holds the multiplier
    logic              ptr;        // round-robin preference when both request
    logic              tmo;        // current job ended by the watchdog
    logic [DR_W-1:0]   drain_cnt;
    logic [WD_W-1:0]   wdog;
    logic [2*VEC_W-1:0] res_q;
    logic              err_q;
    logic [VEC_W-1:0]  mul_a_q, mul_b_q;

    logic              grant;
    logic              gnt_id;
    logic              expire;
    logic              wait_fin;
    logic              wait_tmo;

    // The pointer only matters on a tie; a lone requester always wins.
    always_comb begin
        gnt_id = ptr;
        if (req_vld_i == 2'b10)
            gnt_id = 1'b1;
        else if (req_vld_i == 2'b01)
            gnt_id = 1'b0;
    end

    // The watchdog counts WAIT cycles from 0, so the last WAIT cycle is
    // exactly TIMEOUT cycles after ISSUE.
    assign expire   = (wdog == WD_W'(TIMEOUT - 1));
    // A finish in the expiry cycle still wins over the watchdog.
    assign wait_fin = (state == S_WAIT) && mul_fin_i;
    assign wait_tmo = (state == S_WAIT) && !mul_fin_i && expire;

    always_comb begin
        state_n = state;
        grant   = 1'b0;
        case (state)
            S_DRAIN: begin
                if (drain_cnt == DR_W'(DRAIN - 1))
                    state_n = S_IDLE;
            end
            S_IDLE: begin
                if (|req_vld_i) begin
                    grant   = 1'b1;
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: state_n = S_WAIT;
            S_WAIT: begin
                if (mul_fin_i || expire)
                    state_n = S_DONE;
            end
            S_DONE:  state_n = tmo ? S_DRAIN : S_IDLE;
            default: state_n = S_DRAIN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
            wdog      <= '0;
            ptr       <= 1'b0;
            owner     <= 1'b0;
            tmo       <= 1'b0;
            err_q     <= 1'b0;
            res_q     <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
        end else begin
            state <= state_n;

            // Restart the drain count whenever DONE may lead back into DRAIN.
            if (state == S_DRAIN)
                drain_cnt <= drain_cnt + 1'b1;
            else if (state == S_DONE)
                drain_cnt <= '0;

            if (grant) begin
                owner   <= gnt_id;
                mul_a_q <= req[gnt_id].a;
                mul_b_q <= req[gnt_id].b;
            end

            if (state == S_ISSUE) begin
                ptr  <= ~owner;
                wdog <= '0;
                tmo  <= 1'b0;
            end

            if (state == S_WAIT)
                wdog <= wdog + 1'b1;

            if (wait_fin)
                res_q <= mul_r_i;
            else if (wait_tmo) begin
                res_q <= '0;
                err_q <= 1'b1;
                tmo   <= 1'b1;
            end
        end
    end

    genvar ch;
    generate
        for (ch = 0; ch < NUM_LANES; ch++) begin : g_lane
            mul_arb_256b_2ch_lane u_lane (
                .is_owner (owner == 1'(ch)),
                .in_issue (state == S_ISSUE),
                .in_done  (state == S_DONE),
                .ack      (ack_o[ch]),
                .done     (done_o[ch])
            );
        end
    endgenerate

    assign mul_vld_o = (state == S_ISSUE);
    assign busy_o    = (state != S_IDLE);
    assign res_o     = res_q;
    assign err_o     = err_q;
    assign mul_a_o   = mul_a_q;
    assign mul_b_o   = mul_b_q;

endmodule

// File: tb/tb_mul_arb_256b_2ch.sv
// Directed bench for mul_arb_256b_2ch with a behavioural multiplier whose
// latency is programmable (0 = never finishes).
module tb_mul_arb_256b_2ch;
    localparam int TIMEOUT = 32;
    localparam int DRAIN   = 18;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   req_vld_i = '0;
    logic [255:0] req0_a_i = '0, req0_b_i = '0, req1_a_i = '0, req1_b_i = '0;
    logic [1:0]   ack_o, done_o;
    logic [511:0] res_o;
    logic         err_o, busy_o, mul_vld_o;
    logic [255:0] mul_a_o, mul_b_o;
    logic         mul_fin_i;
    logic [511:0] mul_r_i;

    int checks = 0;
    int errors = 0;

    // Multiplier model: a rising start edge loads a countdown, and finish
    // fires exactly lat cycles after the start cycle.
    int           lat   = 17;
    int           mcnt  = 0;
    logic         vld_q = 1'b0;
    logic [511:0] mprod = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        vld_q <= mul_vld_o;
        if (mul_vld_o && !vld_q && lat > 0) begin
            mcnt  <= lat;
            mprod <= {256'b0, mul_a_o} * {256'b0, mul_b_o};
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
        end
    end

    assign mul_fin_i = (mcnt == 1);
    assign mul_r_i   = mul_fin_i ? mprod : {16{32'hDEADBEEF}};

    mul_arb_256b_2ch #(.TIMEOUT(TIMEOUT), .DRAIN(DRAIN)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_vld_i (req_vld_i),
        .req0_a_i  (req0_a_i),
        .req0_b_i  (req0_b_i),
        .req1_a_i  (req1_a_i),
        .req1_b_i  (req1_b_i),
        .ack_o     (ack_o),
        .done_o    (done_o),
        .res_o     (res_o),
        .err_o     (err_o),
        .busy_o    (busy_o),
        .mul_vld_o (mul_vld_o),
        .mul_a_o   (mul_a_o),
        .mul_b_o   (mul_b_o),
        .mul_fin_i (mul_fin_i),
        .mul_r_i   (mul_r_i)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [511:0] maxsq;
    logic         flag;

    initial begin
        // (2^256-1)^2 = 2^512 - 2^257 + 1
        maxsq = {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1};

        // Reset state
        tick(2);
        chk("rst_ack", ack_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_vld", mul_vld_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_res", res_o, 0);
        chk("rst_mul_a", mul_a_o, 0);
        chk("rst_busy", busy_o, 1);

        // Request from the first drain cycle: 18 DRAIN + 1 IDLE before ack
        rst       = 1'b0;
        req_vld_i = 2'b01;
        req0_a_i  = '1;
        req0_b_i  = '1;
        flag = 1'b0;
        for (int i = 0; i < DRAIN; i++) begin
            flag |= (ack_o != 2'b00);
            tick(1);
        end
        chk("drain_no_ack", flag, 0);
        chk("drain_to_idle", busy_o, 0);
        chk("idle_no_ack", ack_o, 0);
        tick(1);
        chk("j0_ack", ack_o, 2'b01);
        chk("j0_vld", mul_vld_o, 1);
        chk("j0_mul_a", mul_a_o, {256'b0, {256{1'b1}}});
        req_vld_i = 2'b00;
        flag = 1'b0;
        for (int i = 0; i < 17; i++) begin
            tick(1);
            flag |= mul_vld_o | (|done_o) | (|ack_o);
        end
        chk("j0_quiet_wait", flag, 0);
        tick(1);
        chk("j0_done", done_o, 2'b01);
        chk("j0_res", res_o, maxsq);
        tick(1);
        chk("j0_idle", busy_o, 0);
        chk("j0_done_drop", done_o, 0);
        chk("j0_res_hold", res_o, maxsq);

        // Both channels continuously: pointer now names channel 1
        req_vld_i = 2'b11;
        req0_a_i = 256'd7;  req0_b_i = 256'd11;
        req1_a_i = 256'd13; req1_b_i = 256'd17;
        for (int j = 0; j < 4; j++) begin
            tick(1);
            chk("rr_ack", ack_o, (j % 2 == 0) ? 2'b10 : 2'b01);
            chk("rr_vld", mul_vld_o, 1);
            tick(18);
            chk("rr_done", done_o, (j % 2 == 0) ? 2'b10 : 2'b01);
            chk("rr_res", res_o, (j % 2 == 0) ? 512'd221 : 512'd77);
            if (j == 3) req_vld_i = 2'b00;
            tick(1);
            chk("rr_gap_vld", mul_vld_o, 0);
            chk("rr_gap_idle", busy_o, 0);
        end

        // Channel 1 alone, then both: channel 0 wins next
        req_vld_i = 2'b10;
        tick(1);
        chk("c1_ack", ack_o, 2'b10);
        req_vld_i = 2'b11;
        tick(18);
        chk("c1_done", done_o, 2'b10);
        chk("c1_res", res_o, 221);
        tick(1);
        chk("c1_vld_low", mul_vld_o, 0);
        tick(1);
        chk("c0_after_c1_ack", ack_o, 2'b01);
        chk("c0_after_c1_vld", mul_vld_o, 1);
        req_vld_i = 2'b00;
        tick(18);
        chk("c0_after_c1_done", done_o, 2'b01);
        chk("c0_after_c1_res", res_o, 77);
        tick(1);

        // Watchdog timeout: the multiplier never finishes
        lat = 0;
        req_vld_i = 2'b01;
        tick(1);
        chk("to_ack", ack_o, 2'b01);
        req_vld_i = 2'b00;
        tick(TIMEOUT);
        chk("to_not_yet_done", done_o, 0);
        chk("to_not_yet_err", err_o, 0);
        tick(1);
        chk("to_done", done_o, 2'b01);
        chk("to_res_zero", res_o, 0);
        chk("to_err", err_o, 1);
        lat = 17;
        req_vld_i = 2'b10;
        flag = 1'b0;
        for (int i = 0; i < DRAIN; i++) begin
            tick(1);
            flag |= (|ack_o) | ~busy_o;
        end
        chk("to_drain_hold", flag, 0);
        tick(1);
        chk("to_idle", busy_o, 0);
        tick(1);
        chk("to_next_ack", ack_o, 2'b10);
        req_vld_i = 2'b00;
        tick(18);
        chk("to_next_done", done_o, 2'b10);
        chk("to_next_res", res_o, 221);
        chk("to_err_sticky", err_o, 1);
        tick(1);

        // Reset during WAIT; the late finish lands in DRAIN
        req_vld_i = 2'b01;
        req0_a_i = 256'd7; req0_b_i = 256'd11;
        tick(1);
        chk("rw_ack", ack_o, 2'b01);
        req_vld_i = 2'b00;
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rw_err_clr", err_o, 0);
        chk("rw_res_clr", res_o, 0);
        chk("rw_busy", busy_o, 1);
        req_vld_i = 2'b01;
        req0_a_i = 256'd3; req0_b_i = 256'd5;
        flag = 1'b0;
        for (int i = 0; i < DRAIN; i++) begin
            flag |= (|done_o) | (|ack_o);
            tick(1);
        end
        chk("rw_no_done", flag, 0);
        chk("rw_res_zero", res_o, 0);
        chk("rw_idle", busy_o, 0);
        tick(1);
        chk("rw_next_ack", ack_o, 2'b01);
        req_vld_i = 2'b00;
        tick(18);
        chk("rw_next_done", done_o, 2'b01);
        chk("rw_next_res", res_o, 15);
        tick(1);

        // Finish coincident with watchdog expiry: finish wins
        lat = TIMEOUT;
        req_vld_i = 2'b10;
        tick(1);
        chk("co_ack", ack_o, 2'b10);
        req_vld_i = 2'b00;
        tick(TIMEOUT);
        chk("co_not_yet", done_o, 0);
        tick(1);
        chk("co_done", done_o, 2'b10);
        chk("co_res", res_o, 221);
        chk("co_no_err", err_o, 0);
        tick(1);
        chk("co_to_idle", busy_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
